// File: rtl/core_pkg.sv
// Shared execute-stage definitions: register file geometry and ALU op encodings.
// XZR is the architectural zero register index.
package core_pkg;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] XZR = 5'd31;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_op_e;

endpackage

// File: rtl/regfile_rport.sv
// One read port of the register file: selects zero, same-cycle write bypass,
// or stored entry for the given address (combinational).
module regfile_rport
    import core_pkg::*;
#(
    parameter int WIDTH    = XLEN,
    parameter int DEPTH    = NREGS,
    parameter int AW       = REG_AW,
    parameter int ZERO_REG = int'(XZR)
) (
    input  logic [AW-1:0]    i_addr,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wa,
    input  logic [WIDTH-1:0] i_wd,
    input  logic [WIDTH-1:0] i_mem [DEPTH],
    output logic [WIDTH-1:0] o_data
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    // Zero register wins over bypass so a discarded XZR write never leaks out.
    always_comb begin
        o_data = i_mem[i_addr];
        if (i_addr == ZERO_ADDR) begin
            o_data = '0;
        end else if (i_we && (i_wa == i_addr)) begin
            o_data = i_wd;
        end
    end

endmodule

// File: rtl/regfile_64.sv
// 32x64 register file, two registered read ports (write-first bypass) and one
// write port; entry XZR is hardwired to zero.
module regfile_64
    import core_pkg::*;
#(
    parameter int WIDTH    = XLEN,
    parameter int DEPTH    = NREGS,
    parameter int AW       = REG_AW,
    parameter int ZERO_REG = int'(XZR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    regfile_rport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
    ) u_rport_a (
        .i_addr(ra1), .i_we(we), .i_wa(wa), .i_wd(wd), .i_mem(r_mem), .o_data(w_rd1)
    );

    regfile_rport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
    ) u_rport_b (
        .i_addr(ra2), .i_we(we), .i_wa(wa), .i_wd(wd), .i_mem(r_mem), .o_data(w_rd2)
    );

    // rd_en low holds the read registers, which is how the pipeline stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else begin
            if (we && (wa != ZERO_ADDR)) begin
                r_mem[wa] <= wd;
            end
            if (rd_en) begin
                r_rd1 <= w_rd1;
                r_rd2 <= w_rd2;
            end
        end
    end

    assign rd1 = r_rd1;
    assign rd2 = r_rd2;

endmodule

// File: tb/tb_regfile_64.sv
// Scoreboard bench for regfile_64: the driver queues the expected read outputs
// for every cycle it issues; a monitor pops and compares after each clock edge.
module tb_regfile_64;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;

    typedef struct {
        bit          chk;
        logic [63:0] e1;
        logic [63:0] e2;
        string       nm;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    regfile_64 dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .we(we), .wa(wa), .wd(wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk) begin
                total++;
                if (rd1 !== e.e1 || rd2 !== e.e2) begin
                    bad++;
                    $display("FAIL %s: rd1=%h rd2=%h, want rd1=%h rd2=%h",
                             e.nm, rd1, rd2, e.e1, e.e2);
                end
            end
        end
    end

    // Drives one cycle of inputs and queues the outputs expected after its edge.
    task automatic step(input logic r, input logic w, input logic [4:0] a_w,
                        input logic [63:0] d_w, input logic re,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic [63:0] x1, input logic [63:0] x2,
                        input string nm);
        exp_t e;
        rst = r; we = w; wa = a_w; wd = d_w; rd_en = re; ra1 = a1; ra2 = a2;
        e.chk = 1'b1; e.e1 = x1; e.e2 = x2; e.nm = nm;
        q.push_back(e);
        @(negedge clk);
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] DB   = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] PAT  = 64'hA5A5_5A5A_0F0F_F0F0;

    initial begin
        //    rst we wa  wd       rd ra1 ra2  exp1  exp2
        step(1, 0, 0,  0,       0, 0,  0,   0,    0,    "reset_a");
        step(1, 1, 4,  64'h44,  1, 4,  4,   0,    0,    "reset_b");
        step(0, 1, 5,  DB,      0, 0,  0,   0,    0,    "post_reset_hold");
        step(1, 0, 0,  0,       0, 0,  0,   0,    0,    "reset_mid");
        step(0, 0, 0,  0,       1, 5,  0,   0,    0,    "reset_clears_r5");
        step(0, 1, 1,  64'h1,   0, 0,  0,   0,    0,    "write_r1_hold");
        step(0, 1, 2,  ONES,    0, 0,  0,   0,    0,    "write_r2_hold");
        step(0, 0, 0,  0,       1, 1,  2,   64'h1, ONES, "basic_read");
        step(0, 1, 31, 64'hABCD,1, 31, 31,  0,    0,    "xzr_same_cycle");
        step(0, 0, 0,  0,       1, 31, 31,  0,    0,    "xzr_next_cycle");
        step(0, 1, 7,  64'h10,  0, 0,  0,   0,    0,    "write_r7_hold");
        step(0, 1, 7,  64'h20,  1, 7,  7,   64'h20, 64'h20, "bypass_both");
        step(0, 0, 0,  0,       1, 7,  7,   64'h20, 64'h20, "r7_after_bypass");
        step(0, 0, 0,  0,       1, 1,  7,   64'h1, 64'h20, "pre_stall");
        step(0, 1, 1,  64'h9,   0, 2,  2,   64'h1, 64'h20, "stall_1");
        step(0, 0, 0,  0,       0, 2,  2,   64'h1, 64'h20, "stall_2");
        step(0, 0, 0,  0,       0, 2,  2,   64'h1, 64'h20, "stall_3");
        step(0, 0, 0,  0,       1, 1,  2,   64'h9, ONES, "after_stall");
        step(0, 1, 0,  PAT,     1, 0,  1,   PAT,  64'h9, "bypass_r0_port_a");
        step(0, 1, 30, ~PAT,    1, 1,  30,  64'h9, ~PAT, "bypass_r30_port_b");
        step(0, 0, 0,  0,       1, 30, 0,   ~PAT, PAT,  "read_r30_r0");
        step(0, 1, 3,  64'h77,  0, 0,  0,   ~PAT, PAT,  "write_r3_hold");
        step(0, 0, 0,  0,       1, 3,  31,  64'h77, 0,  "read_r3");
        step(1, 1, 3,  64'h55,  1, 3,  3,   0,    0,    "reset_with_write");
        step(0, 0, 0,  0,       1, 3,  3,   0,    0,    "write_discarded");
        step(0, 0, 0,  0,       1, 1,  30,  0,    0,    "all_entries_cleared");
        step(0, 0, 0,  0,       0, 0,  0,   0,    0,    "idle_end");
        rst = 0; we = 0; rd_en = 0;
        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time=%0t limit=100000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_64.md
Name: regfile_64

Overview:
- 32-entry x 64-bit register file with two read ports and one write port.
- Sits directly upstream of the execute-stage ALU: read port A drives the ALU num1 operand, read port B drives num2.
- The writeback stage drives the write port.
- Register 31 is the hardwired zero register (XZR): it always reads 0 and ignores writes.

Parameters:
- WIDTH, 64, data width in bits; matches the ALU operand width.
- DEPTH, 32, number of architectural registers.
- AW, 5, address width; must satisfy 2**AW == DEPTH.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- rd_en  input  1  read strobe; when high, both read addresses are sampled this cycle.
- ra1  input  AW  read address, port A.
- ra2  input  AW  read address, port B.
- rd1  output  WIDTH  read data, port A (to ALU num1); registered.
- rd2  output  WIDTH  read data, port B (to ALU num2); registered.
- we  input  1  write enable.
- wa  input  AW  write address.
- wd  input  WIDTH  write data.

Behaviour:
- Reset:
  - When rst=1 at a rising clk edge, all DEPTH entries clear to 0 and rd1/rd2 clear to 0.
  - A write presented in that same cycle is discarded.
  - Reset asserted mid-stream overrides any pending read or write.
  - rd1/rd2 are 0 on the first edge after rst deasserts, unless a read happens in that cycle.
- Writes:
  - On a rising edge with rst=0, we=1 and wa!=ZERO_REG, entry[wa] takes wd.
  - A write with wa==ZERO_REG has no effect.
  - we=0 leaves every entry unchanged.
- Reads:
  - Synchronous, one-cycle latency.
  - On a rising edge with rst=0 and rd_en=1, rd1 takes the value of ra1 and rd2 takes the value of ra2.
  - rd_en=0: rd1/rd2 hold their previous values (this is the pipeline stall behaviour).
- Read value rule, for each port independently, given address x:
  - x==ZERO_REG: 0.
  - else if we=1 and wa==x in the same cycle: wd (write-first bypass, so a same-cycle writeback is visible with no extra hazard cycle).
  - else: entry[x].
- Simultaneous events:
  - Both ports may read the same address; both return the same value.
  - The bypass applies to both ports at once.
  - A write to ZERO_REG is never bypassed; that port reads 0.
- Width:
  - No arithmetic is performed.
  - Data is stored and returned bit-exact, all WIDTH bits.
  - Addresses are treated as unsigned.
  - With the default DEPTH, every AW-bit address is legal.
- X handling:
  - Outputs must never be X or Z after reset.
  - Read data is undefined only if wd is X.

Decomposition:
- Shared package (core_pkg) holds:
  - XLEN=64, NREGS=32, REG_AW=5, XZR=5'd31.
  - ALU op encodings used by the execute stage: AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110, PASSB=4'b0111, NOR=4'b1100.
- One sub-module is natural: regfile_rport, which encapsulates the zero/bypass/storage select for one read port and is instantiated twice.
- The storage array and write logic stay in regfile_64.

Test Plan:
- Reset, all entries:
  - Stimulus: write 64'hDEAD_BEEF_0123_4567 to r5, assert rst for 1 cycle, then read ra1=5, ra2=0.
  - Required: rd1=0, rd2=0 one cycle after the read; rd1/rd2=0 during and right after reset.
- Basic write/read:
  - Stimulus: write r1=64'h1, r2=64'hFFFF_FFFF_FFFF_FFFF; next cycle read ra1=1, ra2=2.
  - Required: one cycle later rd1=64'h1 and rd2=64'hFFFF_FFFF_FFFF_FFFF.
- Zero register:
  - Stimulus: we=1, wa=31, wd=64'hABCD; same cycle and next cycle read ra1=31, ra2=31.
  - Required: rd1=rd2=0 in both cycles.
- Write-first bypass:
  - Stimulus: r7 holds 64'h10; in one cycle drive we=1, wa=7, wd=64'h20, rd_en=1, ra1=7, ra2=7.
  - Required: rd1=rd2=64'h20 next cycle; subsequent read of r7 also returns 64'h20.
- Stall hold:
  - Stimulus: read r1 to get rd1=64'h1; then rd_en=0 for 3 cycles while ra1=2 and r1 is overwritten with 64'h9.
  - Required: rd1 stays 64'h1 for all 3 cycles; after rd_en=1 with ra1=1, rd1=64'h9.
- Reset mid-write:
  - Stimulus: rst=1 and we=1, wa=3, wd=64'h55 in the same cycle, then read r3.
  - Required: rd1=0 (write discarded).
